systolic_feeder_4x4: RTL and testbench

Source side of the 4x4 systolic array's operand interface. Holds one 4x4 A (activation) matrix and one 4x4 B (weight) matrix loaded over a simple write port. On start it emits the diagonally skewed row/column streams and the MAC write-enable that the array consumes, so that PE(i,j) accumulates sum_k A[i][k]*B[k][j]. Sits between the host/load controller and the array's a_in0..3, b_in0..3 and we inputs.

---
 rtl/systolic_feeder_4x4.sv | 150 +++++++++++++++
 tb/tb_systolic_feeder_4x4.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_4x4.sv
// Operand feeder for a 4x4 systolic array: stores A and B matrices and
// replays them as diagonally skewed row/column streams with MAC enable.
module systolic_feeder_4x4 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_sel,
    input  logic [3:0]            ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  acc_clr,
    output logic                  we_out,
    output logic [DATA_WIDTH-1:0] a_out0,
    output logic [DATA_WIDTH-1:0] a_out1,
    output logic [DATA_WIDTH-1:0] a_out2,
    output logic [DATA_WIDTH-1:0] a_out3,
    output logic [DATA_WIDTH-1:0] b_out0,
    output logic [DATA_WIDTH-1:0] b_out1,
    output logic [DATA_WIDTH-1:0] b_out2,
    output logic [DATA_WIDTH-1:0] b_out3,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [3:0] step_q, step_d;

    logic [DATA_WIDTH-1:0] a_mem_q [16];
    logic [DATA_WIDTH-1:0] b_mem_q [16];

    logic ld_ready_q, ld_ready_d;
    logic busy_q, busy_d;
    logic acc_clr_q, acc_clr_d;
    logic we_q, we_d;
    logic done_q, done_d;
    logic [3:0][DATA_WIDTH-1:0] a_q, a_d;
    logic [3:0][DATA_WIDTH-1:0] b_q, b_d;

    logic wr_en;

    // Writes are only accepted while the feeder advertises ready (IDLE).
    assign wr_en = ld_valid && ld_ready_q;

    // Operand storage; cleared on reset, written from the load port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                a_mem_q[i] <= '0;
                b_mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            if (ld_sel) b_mem_q[ld_addr] <= ld_data;
            else        a_mem_q[ld_addr] <= ld_data;
        end
    end

    // Next state plus output values decoded from the next state, so every
    // output is a flop that lines up with the state it describes.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    step_d  = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                step_d  = '0;
            end
            S_STREAM: begin
                if (step_q == 4'd9) state_d = S_DONE;
                else                step_d  = step_q + 4'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ld_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        acc_clr_d  = (state_d == S_CLEAR);
        we_d       = (state_d == S_STREAM);
        done_d     = (state_d == S_DONE);
        a_d        = '0;
        b_d        = '0;
        if (state_d == S_STREAM) begin
            // Row i carries A[i][t-i]; column j carries B[t-j][j].
            for (int unsigned i = 0; i < 4; i++) begin
                if (step_d >= 4'(i) && (step_d - 4'(i)) <= 4'd3) begin
                    a_d[i] = a_mem_q[{2'(i), 2'(step_d - 4'(i))}];
                    b_d[i] = b_mem_q[{2'(step_d - 4'(i)), 2'(i)}];
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            acc_clr_q  <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            ld_ready_q <= ld_ready_d;
            busy_q     <= busy_d;
            acc_clr_q  <= acc_clr_d;
            we_q       <= we_d;
            done_q     <= done_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    assign ld_ready = ld_ready_q;
    assign busy     = busy_q;
    assign acc_clr  = acc_clr_q;
    assign we_out   = we_q;
    assign done     = done_q;
    assign a_out0   = a_q[0];
    assign a_out1   = a_q[1];
    assign a_out2   = a_q[2];
    assign a_out3   = a_q[3];
    assign b_out0   = b_q[0];
    assign b_out1   = b_q[1];
    assign b_out2   = b_q[2];
    assign b_out3   = b_q[3];

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Directed self-checking bench for systolic_feeder_4x4.
module tb_systolic_feeder_4x4;

    logic       clk;
    logic       rst;
    logic       ld_valid;
    logic       ld_ready;
    logic       ld_sel;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic       start;
    logic       busy;
    logic       acc_clr;
    logic       we_out;
    logic [7:0] a_out0, a_out1, a_out2, a_out3;
    logic [7:0] b_out0, b_out1, b_out2, b_out3;
    logic       done;

    logic [7:0] a_o [4];
    logic [7:0] b_o [4];
    logic [7:0] ma  [16];
    logic [7:0] mb  [16];

    int checks;
    int failures;

    systolic_feeder_4x4 #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_sel   (ld_sel),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .busy     (busy),
        .acc_clr  (acc_clr),
        .we_out   (we_out),
        .a_out0   (a_out0),
        .a_out1   (a_out1),
        .a_out2   (a_out2),
        .a_out3   (a_out3),
        .b_out0   (b_out0),
        .b_out1   (b_out1),
        .b_out2   (b_out2),
        .b_out3   (b_out3),
        .done     (done)
    );

    assign a_o[0] = a_out0;
    assign a_o[1] = a_out1;
    assign a_o[2] = a_out2;
    assign a_o[3] = a_out3;
    assign b_o[0] = b_out0;
    assign b_o[1] = b_out1;
    assign b_o[2] = b_out2;
    assign b_o[3] = b_out3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_a(int i, int t);
        int k;
        k = t - i;
        if (k >= 0 && k <= 3) return ma[i*4 + k];
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_b(int j, int t);
        int k;
        k = t - j;
        if (k >= 0 && k <= 3) return mb[k*4 + j];
        return 8'h00;
    endfunction

    task automatic load(input logic sel, input int addr, input logic [7:0] data);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_addr  = 4'(addr);
        ld_data  = data;
        check("ld_ready_load", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        if (sel) mb[addr] = data;
        else     ma[addr] = data;
    endtask

    // Cycle c counts from the cycle after start was sampled (c=1 is CLEAR).
    task automatic check_cycle(input int c);
        bit instream;
        int t;
        instream = (c >= 2 && c <= 11);
        t = c - 2;
        check($sformatf("acc_clr@c%0d", c), acc_clr, (c == 1));
        check($sformatf("busy@c%0d", c), busy, (c <= 12));
        check($sformatf("we_out@c%0d", c), we_out, instream);
        check($sformatf("done@c%0d", c), done, (c == 12));
        check($sformatf("ld_ready@c%0d", c), ld_ready, (c == 13));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("a_out%0d@c%0d", i, c), a_o[i], instream ? exp_a(i, t) : 8'h00);
            check($sformatf("b_out%0d@c%0d", i, c), b_o[i], instream ? exp_b(i, t) : 8'h00);
        end
    endtask

    task automatic run_pass(input bit poke, input bit hand, input bit wr, input logic [7:0] wdata);
        start = 1'b1;
        if (wr) begin
            ld_valid = 1'b1;
            ld_sel   = 1'b0;
            ld_addr  = 4'd0;
            ld_data  = wdata;
        end
        tick();
        start    = 1'b0;
        ld_valid = 1'b0;
        if (wr) ma[0] = wdata;
        for (int c = 1; c <= 13; c++) begin
            start = poke && (c == 5 || c == 9);
            if (poke && c == 6) begin
                ld_valid = 1'b1;
                ld_sel   = 1'b0;
                ld_addr  = 4'd0;
                ld_data  = 8'hFF;
            end else begin
                ld_valid = 1'b0;
            end
            check_cycle(c);
            if (hand) begin
                if (c >= 2 && c <= 5) check("a_out0_hand", a_out0, 32'(c - 1));
                if (c >= 5 && c <= 8) check("a_out3_hand", a_out3, 32'(13 + c - 5));
                if (c >= 2 && c <= 11) check("b_out2_hand", b_out2, (c == 6) ? 1 : 0);
            end
            tick();
        end
        start    = 1'b0;
        ld_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_sel   = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        start    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ma[i] = 8'h00;
            mb[i] = 8'h00;
        end
        tick();
        tick();
        rst = 1'b0;

        // Reset and idle for 5 cycles.
        for (int c = 0; c < 5; c++) begin
            check("idle_ld_ready", ld_ready, 1);
            check("idle_busy", busy, 0);
            check("idle_acc_clr", acc_clr, 0);
            check("idle_we_out", we_out, 0);
            check("idle_done", done, 0);
            check("idle_a", {a_out0, a_out1, a_out2, a_out3}, 0);
            check("idle_b", {b_out0, b_out1, b_out2, b_out3}, 0);
            tick();
        end

        // A[i][k] = 4i+k+1 (A[1][1] first written with a stale value), B = I.
        load(1'b0, 5, 8'hAA);
        for (int a = 0; a < 16; a++) load(1'b0, a, 8'(a + 1));
        for (int d = 0; d < 4; d++) load(1'b1, d*5, 8'h01);

        run_pass(1'b0, 1'b1, 1'b0, 8'h00);
        // Extra starts and a write during the pass must be ignored.
        run_pass(1'b1, 1'b0, 1'b0, 8'h00);
        // Replay shows identical streams (0xFF write never landed).
        run_pass(1'b0, 1'b1, 1'b0, 8'h00);
        // Write and start in the same IDLE cycle: stream uses new A[0][0].
        run_pass(1'b0, 1'b0, 1'b1, 8'h7F);

        // Reset during step t=4.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        check("pre_rst_we_out", we_out, 1);
        check("pre_rst_a_out0", a_out0, 0);
        check("pre_rst_a_out2", a_out2, 8'd11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_we_out", we_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_acc_clr", acc_clr, 0);
        check("rst_done", done, 0);
        check("rst_a", {a_out0, a_out1, a_out2, a_out3}, 0);
        check("rst_b", {b_out0, b_out1, b_out2, b_out3}, 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        for (int i = 0; i < 16; i++) begin
            ma[i] = 8'h00;
            mb[i] = 8'h00;
        end
        run_pass(1'b0, 1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
